// File: rtl/sfr_access_ctrl_pkg.sv
// Shared types and helpers for the SFR access controller (package sfr_pkg).
// Holds the access FSM state enum, default window placement and the
// byte-enable to bit-mask expansion used by the store merge.
package sfr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } sfr_acc_state_t;

  localparam logic [31:0] SFR_BASE_DEF = 32'h0001_0000;
  localparam int          SFR_NUM_DEF  = 16;

  // Widest SFR the mask helper supports; narrower SFRs truncate the result.
  localparam int SFR_WIDTH_MAX = 128;
  localparam int SFR_BE_MAX    = SFR_WIDTH_MAX / 8;

  function automatic logic [SFR_WIDTH_MAX-1:0] be_to_mask(input logic [SFR_BE_MAX-1:0] be);
    logic [SFR_WIDTH_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < SFR_BE_MAX; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sfr_access_ctrl_if.sv
// Core data-port and SFR-map signals of the SFR access controller.
// slave  : the controller side.
// master : the core / SFR map side (drives requests, SFR read data and masks).
interface sfr_access_ctrl_if #(
  parameter int SFR_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SFR_NUM    = 16
);
  localparam int BE_W  = SFR_WIDTH / 8;
  localparam int IDX_W = $clog2(SFR_NUM);

  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [BE_W-1:0]       cpu_be;
  logic [SFR_WIDTH-1:0]  cpu_wdata;
  logic [SFR_WIDTH-1:0]  cpu_rdata;
  logic                  cpu_ready;
  logic                  cpu_err;

  logic [IDX_W-1:0]      sfr_idx;
  logic                  sfr_wen;
  logic [SFR_WIDTH-1:0]  sfr_din;
  logic [SFR_WIDTH-1:0]  sfr_dout;
  logic [SFR_WIDTH-1:0]  sfr_wmask;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata, sfr_dout, sfr_wmask,
    output cpu_rdata, cpu_ready, cpu_err, sfr_idx, sfr_wen, sfr_din
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata, sfr_dout, sfr_wmask,
    input  cpu_rdata, cpu_ready, cpu_err, sfr_idx, sfr_wen, sfr_din
  );

endinterface

// File: rtl/sfr_access_ctrl_addr_decode.sv
// Combinational SFR window decoder: byte address -> {hit, misaligned, idx}.
// Kept free of state so a debug port can reuse it next to the core path.
module sfr_addr_decode #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] SFR_BASE   = ADDR_WIDTH'(32'h0001_0000),
  parameter int                    SFR_NUM    = 16
) (
  input  logic [ADDR_WIDTH-1:0]      i_addr,
  output logic                       o_hit,
  output logic                       o_misaligned,
  output logic [$clog2(SFR_NUM)-1:0] o_idx
);
  localparam int IDX_W = $clog2(SFR_NUM);

  // One extra bit so a window ending at the top of the address space
  // does not wrap the upper bound.
  localparam logic [ADDR_WIDTH:0] ADDR_LO = {1'b0, SFR_BASE};
  localparam logic [ADDR_WIDTH:0] ADDR_HI = ADDR_LO + (ADDR_WIDTH+1)'(4 * SFR_NUM);

  logic [ADDR_WIDTH:0]   w_addr_ext;
  logic [ADDR_WIDTH-1:0] w_off;

  assign w_addr_ext   = {1'b0, i_addr};
  assign o_hit        = (w_addr_ext >= ADDR_LO) && (w_addr_ext < ADDR_HI);
  assign o_misaligned = |i_addr[1:0];
  assign w_off        = i_addr - SFR_BASE;
  assign o_idx        = IDX_W'(w_off >> 2);

endmodule

// File: rtl/sfr_access_ctrl.sv
// SFR access controller: sequences core load/store requests into the SFR
// map's full-word write port. Partial stores become read-modify-write
// cycles and only bits flagged writable by the map are ever changed.
//
// Optional feature: SFR_ACCESS_FAST_WR_EN - full-word stores skip READ and
// merge against the live sfr_dout while in WRITE.
//
//   state | meaning
//   IDLE  | wait for cpu_req, capture request, decode address
//   READ  | latch current SFR value (load result / merge base)
//   WRITE | drive merged word, strobe sfr_wen if any bit is writable
//   RESP  | one-cycle cpu_ready with rdata/err
module sfr_access_ctrl
  import sfr_pkg::*;
#(
  parameter int                    SFR_WIDTH  = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] SFR_BASE   = ADDR_WIDTH'(SFR_BASE_DEF),
  parameter int                    SFR_NUM    = SFR_NUM_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             sys_clk_en,
  sfr_access_ctrl_if.slave bus
);
  localparam int BE_W  = SFR_WIDTH / 8;
  localparam int IDX_W = $clog2(SFR_NUM);

  sfr_acc_state_t r_state;
  sfr_acc_state_t w_state_nxt;

  logic                 r_we;
  logic [BE_W-1:0]      r_be;
  logic [SFR_WIDTH-1:0] r_wdata;
  logic [IDX_W-1:0]     r_idx;
  logic [SFR_WIDTH-1:0] r_old;
  logic [SFR_WIDTH-1:0] r_rdata;
  logic                 r_err;

  logic                 w_dec_hit;
  logic                 w_dec_misaligned;
  logic [IDX_W-1:0]     w_dec_idx;
  logic                 w_dec_err;

  logic [SFR_WIDTH-1:0] w_bm;
  logic [SFR_WIDTH-1:0] w_eff;
  logic [SFR_WIDTH-1:0] w_old;
  logic [SFR_WIDTH-1:0] w_merged;
  logic                 w_blocked;

  sfr_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SFR_BASE   (SFR_BASE),
    .SFR_NUM    (SFR_NUM)
  ) u_addr_decode (
    .i_addr       (bus.cpu_addr),
    .o_hit        (w_dec_hit),
    .o_misaligned (w_dec_misaligned),
    .o_idx        (w_dec_idx)
  );

  assign w_dec_err = !w_dec_hit || w_dec_misaligned;

`ifdef SFR_ACCESS_FAST_WR_EN
  logic r_fast;
  logic w_fast_req;

  assign w_fast_req = bus.cpu_we && (&bus.cpu_be);
  // Fast stores never passed through READ, so r_old is stale for them.
  assign w_old      = r_fast ? bus.sfr_dout : r_old;
`else
  assign w_old      = r_old;
`endif

  assign w_bm      = SFR_WIDTH'(be_to_mask(SFR_BE_MAX'(r_be)));
  assign w_eff     = w_bm & bus.sfr_wmask;
  assign w_merged  = (w_old & ~w_eff) | (r_wdata & w_eff);
  // Enabled lanes that hit only read-only bits are reported; be=0 is a no-op.
  assign w_blocked = (|w_bm) && !(|w_eff);

  // State register; freezes while the clock enable is low.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= IDLE;
    end else if (sys_clk_en) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.cpu_req) begin
          if (w_dec_err) begin
            w_state_nxt = RESP;
`ifdef SFR_ACCESS_FAST_WR_EN
          end else if (w_fast_req) begin
            w_state_nxt = WRITE;
`endif
          end else begin
            w_state_nxt = READ;
          end
        end
      end
      READ:    w_state_nxt = r_we ? WRITE : RESP;
      WRITE:   w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request capture, old-value latch and response registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_idx   <= '0;
      r_old   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (sys_clk_en) begin
      case (r_state)
        IDLE: begin
          if (bus.cpu_req) begin
            r_we    <= bus.cpu_we;
            r_be    <= bus.cpu_be;
            r_wdata <= bus.cpu_wdata;
            if (w_dec_err) begin
              r_err   <= 1'b1;
              r_rdata <= '0;
            end else begin
              r_idx   <= w_dec_idx;
            end
          end
        end
        READ: begin
          r_old <= bus.sfr_dout;
          if (!r_we) begin
            r_rdata <= bus.sfr_dout;
            r_err   <= 1'b0;
          end
        end
        WRITE: begin
          r_rdata <= w_old;
          r_err   <= w_blocked;
        end
        default: ;
      endcase
    end
  end

`ifdef SFR_ACCESS_FAST_WR_EN
  // Remember whether the current store took the READ-less path.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_fast <= 1'b0;
    end else if (sys_clk_en && (r_state == IDLE) && bus.cpu_req) begin
      r_fast <= w_fast_req && !w_dec_err;
    end
  end
`endif

  // Strobes are gated by the enable and by state, so reset drops them at once.
  assign bus.sfr_wen   = (r_state == WRITE) && sys_clk_en && (|w_eff);
  assign bus.sfr_din   = (r_state == WRITE) ? w_merged : '0;
  assign bus.sfr_idx   = r_idx;
  assign bus.cpu_ready = (r_state == RESP) && sys_clk_en;
  assign bus.cpu_rdata = r_rdata;
  assign bus.cpu_err   = r_err;

endmodule

// File: tb/tb_sfr_access_ctrl.sv
// Self-checking bench for sfr_access_ctrl: the bench plays core and SFR map,
// and predicts every response from a word-array model of the SFR window.
module tb_sfr_access_ctrl;
  localparam int SW   = 32;
  localparam int AW   = 32;
  localparam int NUM  = 16;
  localparam int BEW  = SW / 8;
  localparam int IW   = $clog2(NUM);
  localparam logic [AW-1:0] BASE = 32'h0001_0000;
`ifdef SFR_ACCESS_FAST_WR_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic sys_clk    = 1'b0;
  logic sys_rst    = 1'b1;
  logic sys_clk_en = 1'b1;

  sfr_access_ctrl_if #(.SFR_WIDTH(SW), .ADDR_WIDTH(AW), .SFR_NUM(NUM)) bus ();

  sfr_access_ctrl #(
    .SFR_WIDTH(SW), .ADDR_WIDTH(AW), .SFR_BASE(BASE), .SFR_NUM(NUM)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .sys_clk_en (sys_clk_en),
    .bus        (bus)
  );

  always #5 sys_clk = ~sys_clk;

  logic [SW-1:0] mem     [NUM];
  logic [SW-1:0] wmask   [NUM];
  logic [SW-1:0] ref_mem [NUM];
  int n_wen = 0;
  int n_assert = 0;
  int n_fail = 0;

  assign bus.sfr_dout  = mem[bus.sfr_idx];
  assign bus.sfr_wmask = wmask[bus.sfr_idx];

  always @(posedge sys_clk) begin
    if (bus.sfr_wen) begin
      mem[bus.sfr_idx] <= bus.sfr_din;
      n_wen <= n_wen + 1;
    end
  end

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected stored word: copy each enabled byte's writable bits from wdata.
  function automatic logic [SW-1:0] merge_ref(input logic [SW-1:0] old, input logic [SW-1:0] wd,
                                              input logic [BEW-1:0] be, input logic [SW-1:0] wm);
    logic [SW-1:0] r;
    r = old;
    for (int b = 0; b < BEW; b++)
      if (be[b])
        for (int k = 0; k < 8; k++)
          if (wm[8*b+k]) r[8*b+k] = wd[8*b+k];
    return r;
  endfunction

  function automatic bit writable_ref(input logic [BEW-1:0] be, input logic [SW-1:0] wm);
    bit any;
    any = 1'b0;
    for (int b = 0; b < BEW; b++)
      if (be[b] && (wm[8*b +: 8] != 8'h00)) any = 1'b1;
    return any;
  endfunction

  // One access from the core; stall_len enable-low cycles starting at cycle stall_at.
  task automatic access(input string tag, input bit we, input logic [AW-1:0] addr,
                        input logic [BEW-1:0] be, input logic [SW-1:0] wd,
                        input int stall_at, input int stall_len);
    longint a;
    bit err_dec, fast, exp_err, exp_wen;
    int idx, exp_lat, ready_cyc, wen_cyc, wen0;
    logic [SW-1:0] old, newv, rdata_s, din_s;
    logic [IW-1:0] idx_s;
    logic err_s;

    a       = longint'(addr);
    err_dec = (a < longint'(BASE)) || (a >= longint'(BASE) + 4*NUM) || (a % 4 != 0);
    idx     = err_dec ? 0 : int'((a - longint'(BASE)) / 4);
    old     = ref_mem[idx];
    fast    = FAST && we && (be == {BEW{1'b1}});
    exp_wen = !err_dec && we && writable_ref(be, wmask[idx]);
    exp_err = err_dec || (we && (be != '0) && !writable_ref(be, wmask[idx]));
    newv    = exp_wen ? merge_ref(old, wd, be, wmask[idx]) : old;
    exp_lat = (err_dec ? 1 : (!we ? 2 : (fast ? 2 : 3))) + stall_len;

    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_be    = be;
    bus.cpu_wdata = wd;
    wen0      = n_wen;
    ready_cyc = -1;
    wen_cyc   = -1;
    rdata_s   = '0;
    din_s     = '0;
    idx_s     = '0;
    err_s     = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge sys_clk);
      #1;
      if (stall_len > 0 && cyc == stall_at) sys_clk_en = 1'b0;
      if (stall_len > 0 && cyc == stall_at + stall_len) sys_clk_en = 1'b1;
      if (cyc == 1) begin
        bus.cpu_we    = 1'($urandom);
        bus.cpu_addr  = $urandom;
        bus.cpu_be    = BEW'($urandom);
        bus.cpu_wdata = $urandom;
      end
      @(negedge sys_clk);
      if (bus.sfr_wen === 1'b1) begin
        wen_cyc = cyc;
        din_s   = bus.sfr_din;
        idx_s   = bus.sfr_idx;
      end
      if (bus.cpu_ready === 1'b1) begin
        ready_cyc = cyc;
        rdata_s   = bus.cpu_rdata;
        err_s     = bus.cpu_err;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    sys_clk_en  = 1'b1;
    @(posedge sys_clk);
    #1;
    @(negedge sys_clk);
    check({tag, " latency"}, SW'(ready_cyc), SW'(exp_lat));
    check({tag, " single ready"}, SW'(bus.cpu_ready), '0);
    check({tag, " err"}, SW'(err_s), SW'(exp_err));
    if (!err_dec && !fast) check({tag, " rdata"}, rdata_s, old);
    check({tag, " wen count"}, SW'(n_wen - wen0), SW'(exp_wen));
    if (exp_wen) begin
      check({tag, " din"}, din_s, newv);
      check({tag, " wen idx"}, SW'(idx_s), SW'(idx));
      check({tag, " wen cycle"}, SW'(wen_cyc), SW'(ready_cyc - 1));
      ref_mem[idx] = newv;
    end
    check({tag, " sfr content"}, mem[idx], ref_mem[idx]);
  endtask

  task automatic set_sfr(input int i, input logic [SW-1:0] v, input logic [SW-1:0] m);
    mem[i] = v;
    ref_mem[i] = v;
    wmask[i] = m;
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [BEW-1:0] rbe;
    int kind, sl;
    bit rwe;

    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
    bus.cpu_be = '0; bus.cpu_wdata = '0;
    for (int i = 0; i < NUM; i++) set_sfr(i, $urandom, $urandom);
    set_sfr(5, $urandom, 32'h0000_0000);
    set_sfr(6, $urandom, 32'hFFFF_FFFF);

    repeat (3) @(negedge sys_clk);
    check("reset ready", SW'(bus.cpu_ready), '0);
    check("reset rdata", bus.cpu_rdata, '0);
    check("reset err", SW'(bus.cpu_err), '0);
    check("reset idx", SW'(bus.sfr_idx), '0);
    check("reset wen", SW'(bus.sfr_wen), '0);
    check("reset din", bus.sfr_din, '0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    set_sfr(2, 32'hDEAD_BEEF, $urandom);
    access("load sfr2", 1'b0, BASE + 8, '0, '0, 0, 0);
    set_sfr(1, 32'h1122_3344, 32'hFFFF_FFFF);
    access("store byte1", 1'b1, BASE + 4, 4'b0010, 32'h0000_AB00, 0, 0);
    check("store byte1 literal", mem[1], 32'h1122_AB44);
    set_sfr(3, 32'h0, 32'h0000_00FF);
    access("store full", 1'b1, BASE + 12, 4'hF, 32'hFFFF_FFFF, 0, 0);
    check("store full literal", mem[3], 32'h0000_00FF);
    access("load past window", 1'b0, BASE + 4*NUM, '0, '0, 0, 0);
    access("load misaligned", 1'b0, BASE + 2, '0, '0, 0, 0);
    access("load below window", 1'b0, BASE - 4, '0, '0, 0, 0);
    set_sfr(4, 32'h5566_7788, 32'h00FF_FFFF);
    access("store ro byte", 1'b1, BASE + 16, 4'b1000, 32'hAA00_0000, 0, 0);
    access("store be0", 1'b1, BASE + 16, 4'b0000, 32'hFFFF_FFFF, 0, 0);
    access("load last", 1'b0, BASE + 4*(NUM-1), '0, '0, 0, 0);
    access("load stalled", 1'b0, BASE + 8, '0, '0, 1, 3);

    // Reset while the store is in WRITE: strobe must drop without a clock edge.
    set_sfr(7, 32'h0F0F_0F0F, 32'hFFFF_FFFF);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = BASE + 28;
    bus.cpu_be = 4'b1111; bus.cpu_wdata = 32'h1234_5678;
    @(posedge sys_clk); #1; bus.cpu_req = 1'b0;
    if (!FAST) begin @(posedge sys_clk); #1; end
    check("pre-reset wen", SW'(bus.sfr_wen), 32'd1);
    sys_rst = 1'b1;
    #1;
    check("reset wen drop", SW'(bus.sfr_wen), '0);
    check("reset din drop", bus.sfr_din, '0);
    check("reset idx drop", SW'(bus.sfr_idx), '0);
    check("reset rdata drop", bus.cpu_rdata, '0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("aborted write", mem[7], ref_mem[7]);

    // Reset while a partial store sits in READ: no write may follow.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = BASE + 28;
    bus.cpu_be = 4'b0001; bus.cpu_wdata = 32'hFFFF_FFFF;
    @(posedge sys_clk); #1; bus.cpu_req = 1'b0;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("aborted read", mem[7], ref_mem[7]);
    access("load after reset", 1'b0, BASE + 28, '0, '0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      ra = BASE - AW'($urandom_range(1, 64));
      else if (kind == 1) ra = BASE + AW'(4*NUM) + AW'($urandom_range(0, 64));
      else if (kind == 2) ra = BASE + AW'(4*$urandom_range(0, NUM-1)) + AW'($urandom_range(1, 3));
      else                ra = BASE + AW'(4*$urandom_range(0, NUM-1));
      rwe = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       rbe = '1;
        1:       rbe = '0;
        default: rbe = BEW'($urandom);
      endcase
      sl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      access($sformatf("rand%0d", n), rwe, ra, rbe, $urandom, 1, sl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sfr_access_ctrl.md
# sfr_access_ctrl

Bus-side access controller directly upstream of the SFR map. Accepts single-word load/store requests from the core's data port, decodes the SFR address window and sequences each access into the SFR map's full-word write interface. Byte-enabled stores become read-modify-write cycles. Writes to read-only bits are blocked, and the core gets one response per request, carrying a ready pulse, read data and an error flag.

## Interface
- SFR_WIDTH, 32: data width of every SFR; must be a multiple of 8.
- ADDR_WIDTH, 32: core address width.
- SFR_BASE, 32'h0001_0000: byte address of SFR index 0; word aligned.
- SFR_NUM, 16: number of SFRs in the window; power of two, ≥2.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- sys_clk_en  in  1  global clock enable; FSM advances only when high.
- cpu_req  in  1  access request; held until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_WIDTH  byte address.
- cpu_be  in  SFR_WIDTH/8  byte enables (store only).
- cpu_wdata  in  SFR_WIDTH  store data.
- cpu_rdata  out  SFR_WIDTH  load data, valid with cpu_ready.
- cpu_ready  out  1  one-cycle response pulse.
- cpu_err  out  1  error flag, valid with cpu_ready.
- sfr_idx  out  $clog2(SFR_NUM)  addressed SFR index.
- sfr_wen  out  1  full-word write strobe to SFR map.
- sfr_din  out  SFR_WIDTH  merged write word.
- sfr_dout  in  SFR_WIDTH  current value of SFR[sfr_idx] (combinational in SFR map).
- sfr_wmask  in  SFR_WIDTH  writable-bit mask of SFR[sfr_idx] (combinational).

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - When cpu_req is high, capture addr/we/be/wdata into registers.
  - Decode the captured address:
    - out of window: addr < SFR_BASE or addr ≥ SFR_BASE+4*SFR_NUM.
    - misaligned: addr[1:0]≠0.
    - Either case → RESP with err=1, no SFR access.
  - Otherwise sfr_idx = (addr−SFR_BASE)>>2 and the FSM goes to READ.
- READ: latch sfr_dout into the old-value register.
  - load → RESP, rdata = old value.
  - store → WRITE.
- WRITE:
  - bm = byte-lane mask expanded from be.
  - eff = bm & sfr_wmask.
  - sfr_din = (old & ~eff) | (wdata & eff).
  - sfr_wen=1 iff eff≠0.
  - err=1 iff bm≠0 and eff=0.
  - be=0 is a legal no-op: no wen, err=0.
  - Go to RESP.
- RESP: cpu_ready=1 for one cycle → IDLE. A request still high in the next IDLE cycle is a new access.
- cpu_rdata and cpu_err hold their values until the next RESP. For stores, cpu_rdata holds the pre-write value.
- sys_clk_en low: state and registers freeze; sfr_wen and cpu_ready are forced 0 and reassert when the enable returns.

## Timing
- Reset values: state IDLE, cpu_rdata 0, cpu_ready 0, cpu_err 0, sfr_idx 0, sfr_wen 0, sfr_din 0.
- Cycle 0 = the IDLE cycle with cpu_req high and sys_clk_en high.
- Latencies (cpu_ready cycle):
  - decode error: cycle 1.
  - load: READ cycle 1, ready cycle 2.
  - store: READ cycle 1, WRITE cycle 2 (sfr_wen), ready cycle 3.
- Each cycle with sys_clk_en low adds one cycle of latency.
- sfr_wen is high for exactly one enabled cycle per store; the SFR map samples sfr_din at the end of that cycle.
- Request inputs are don't-care after cycle 0. Changing them mid-access does not alter the access.
- Reset mid-operation: immediate return to IDLE, outputs to reset values. A store aborted in READ performs no write. sfr_wen drops asynchronously.

## Configuration
- SFR_ACCESS_FAST_WR_EN defined:
  - A store whose be is all-ones skips READ: IDLE → WRITE → RESP, ready at cycle 2.
  - Merge uses old = sfr_dout sampled combinationally in WRITE, so read-only bits are preserved.
  - cpu_rdata for such stores is undefined but stable.
- Undefined: all stores use the full READ → WRITE path.

## Structure
- Shared package sfr_pkg holds:
  - state enum sfr_acc_state_t {IDLE, READ, WRITE, RESP}.
  - SFR_BASE and SFR_NUM defaults.
  - byte-enable-to-bit-mask function.
- One sub-module, sfr_addr_decode: purely combinational; addr → {hit, misaligned, idx}. Reusable by debug-port access.

## Test plan
- Load SFR_BASE+8 with SFR[2]=32'hDEAD_BEEF → ready at cycle 2, rdata DEAD_BEEF, err 0, no sfr_wen.
- Store SFR_BASE+4, be=4'b0010, wdata=32'h0000_AB00, old=32'h1122_3344, wmask all-ones → sfr_din 32'h1122_AB44, one-cycle wen at cycle 2, ready cycle 3.
- Store all-ones, be=4'hF, wmask=32'h0000_00FF, old=0 → sfr_din 32'h0000_00FF. With SFR_ACCESS_FAST_WR_EN: ready cycle 2.
- Load SFR_BASE+4*SFR_NUM and load SFR_BASE+2 → ready cycle 1, err 1, no SFR activity.
- Store with be=4'b1000, wmask=32'h00FF_FFFF → err 1, no wen. Separately, be=0 → err 0, no wen.
- sys_rst pulse during WRITE → sfr_wen drops immediately, state IDLE. Separately, sys_clk_en low for 3 cycles mid-load → ready delayed to cycle 5, single pulse.
